fm_wb_result_collector: RTL and testbench
=========================================

// Module: fm_wb_result_collector
// PURPOSE
//  Downstream of the feature x weight dot-product stage. Captures one 16-bit dot-product
//  result per accepted beat and stores it into the FM_WB matrix (NUM_ROWS nodes x NUM_COLS
//  weight columns), filled row-major. Exposes the matrix through a random-access read port
//  and flags completion to the GCN top-level control for the adjacency-multiply stage.
// PARAMETERS
//  NUM_ROWS        6                        nodes (FM_WB rows)
//  NUM_COLS        3                        weight columns (FM_WB columns)
//  DATA_WIDTH      16                       result width, matches dot-product output
//  ROW_ADDR_WIDTH  $clog2(NUM_ROWS)         read/fill row index width (min 1)
//  COL_ADDR_WIDTH  $clog2(NUM_COLS)         read/fill column index width (min 1)
// PORTS
//  clk        in   1               single clock, all logic on posedge
//  reset      in   1               synchronous, active-high
//  start      in   1               begin new matrix fill (honoured in IDLE/DONE only)
//  in_valid   in   1               in_data holds a dot-product result
//  in_data    in   DATA_WIDTH      dot-product result
//  in_ready   out  1               collector accepts a beat this cycle
//  row_done   out  1               1-cycle pulse: last column of a row just written
//  fill_row   out  ROW_ADDR_WIDTH  row the next accepted beat is written to
//  fill_col   out  COL_ADDR_WIDTH  column the next accepted beat is written to
//  busy       out  1               state == COLLECT
//  done       out  1               state == DONE (matrix complete)
//  drop_err   out  1               sticky: in_valid seen while in_ready==0
//  read_row   in   ROW_ADDR_WIDTH  read row address
//  read_col   in   COL_ADDR_WIDTH  read column address
//  read_data  out  DATA_WIDTH      mem[read_row][read_col], combinational
// BEHAVIOUR
//  - Reset (sync, reset=1 at posedge): state=IDLE, fill_row=fill_col=0, row_done=0,
//    drop_err=0, all mem entries=0. Reset mid-fill abandons the fill; no partial done.
//  - FSM: IDLE --start--> COLLECT --last beat accepted--> DONE --start--> COLLECT.
//    start in COLLECT is ignored. No other transitions.
//  - On start (IDLE/DONE): fill_row=fill_col=0, all mem entries cleared to 0, drop_err cleared.
//    Beat may not be accepted in the same cycle as start (in_ready=0 that cycle).
//  - in_ready = (state==COLLECT), purely state-decoded; no dependence on in_valid.
//  - Accept = in_valid && in_ready. On accept: mem[fill_row][fill_col] <= in_data;
//    fill_col++; if fill_col==NUM_COLS-1 then fill_col<=0, fill_row++, row_done=1 next cycle.
//  - Last beat (fill_row==NUM_ROWS-1, fill_col==NUM_COLS-1): row_done pulses, state->DONE,
//    fill_row/fill_col wrap to 0. done asserts the cycle after the last accept and holds
//    until start or reset.
//  - Beats need not be contiguous: in_valid gaps simply stall counters.
//  - drop_err set on any in_valid=1 while in_ready=0 (IDLE, DONE, start cycle); beat discarded,
//    counters/mem untouched. Cleared only by reset or start.
//  - in_data stored verbatim, no saturation/truncation (widths equal).
//  - read_data = mem[read_row][read_col]; read_row>=NUM_ROWS or read_col>=NUM_COLS -> 0.
//    Read-during-write of same entry returns the old value (write lands at posedge).
//  - Latency: accept at edge N -> visible on read_data after edge N; done after edge of last accept.
// TESTING
//  1 reset, start, 18 beats in_data=1..18 back-to-back -> row_done pulses 6x, done=1 after 18th;
//    read (0,0)=1, (0,2)=3, (1,0)=4, (5,2)=18.
//  2 same fill with in_valid low on every other cycle -> identical matrix, done after 18 accepts,
//    drop_err=0.
//  3 in_valid=1 in IDLE, and in DONE with in_data=0xFFFF -> drop_err=1, matrix unchanged;
//    next start -> drop_err=0, all entries read 0.
//  4 start asserted mid-fill after 7 beats -> ignored: fill_row=2, fill_col=1 unchanged;
//    remaining 11 beats complete normally.
//  5 reset after 10 beats -> next cycle state IDLE, busy=0, done=0, all entries 0, counters 0.
//  6 read_row=6 or read_col=3 -> read_data=0; write (2,1)=0xBEEF while reading (2,1) -> old
//    value that cycle, 0xBEEF next cycle.

Source files
------------

// File: rtl/fm_wb_result_collector_if.sv
// Handshake, fill-status and read-port bundle between the dot-product result stream
// and the FM_WB result collector.
interface fm_wb_result_collector_if #(
  parameter int NUM_ROWS       = 6,
  parameter int NUM_COLS       = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int ROW_ADDR_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  parameter int COL_ADDR_WIDTH = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
);
  logic                      start;
  logic                      in_valid;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      in_ready;
  logic                      row_done;
  logic [ROW_ADDR_WIDTH-1:0] fill_row;
  logic [COL_ADDR_WIDTH-1:0] fill_col;
  logic                      busy;
  logic                      done;
  logic                      drop_err;
  logic [ROW_ADDR_WIDTH-1:0] read_row;
  logic [COL_ADDR_WIDTH-1:0] read_col;
  logic [DATA_WIDTH-1:0]     read_data;

  modport master (
    output start, in_valid, in_data, read_row, read_col,
    input  in_ready, row_done, fill_row, fill_col, busy, done, drop_err, read_data
  );

  modport slave (
    input  start, in_valid, in_data, read_row, read_col,
    output in_ready, row_done, fill_row, fill_col, busy, done, drop_err, read_data
  );
endinterface

// File: rtl/fm_wb_result_collector.sv
// Collects dot-product results row-major into the NUM_ROWS x NUM_COLS FM_WB matrix,
// exposes it through a combinational read port and flags completion.
module fm_wb_result_collector #(
  parameter int NUM_ROWS       = 6,
  parameter int NUM_COLS       = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int ROW_ADDR_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  parameter int COL_ADDR_WIDTH = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  fm_wb_result_collector_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;

  localparam logic [ROW_ADDR_WIDTH-1:0] ROW_LAST = ROW_ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [COL_ADDR_WIDTH-1:0] COL_LAST = COL_ADDR_WIDTH'(NUM_COLS - 1);

  state_e                    state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [COL_ADDR_WIDTH-1:0] col_q, col_d;
  logic                      row_done_q, row_done_d;
  logic                      drop_err_q, drop_err_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

  logic in_ready;
  logic start_go;
  logic accept;
  logic last_col;
  logic last_row;

  // start is only honoured outside COLLECT, and in_ready is low on that cycle
  assign start_go = bus.start && (state_q != S_COLLECT);
  assign accept   = bus.in_valid && in_ready;
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      row_done_q <= 1'b0;
      drop_err_q <= 1'b0;
      mem_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row_done_q <= row_done_d;
      drop_err_q <= drop_err_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_COLLECT;
      S_COLLECT: if (accept && last_row && last_col) state_d = S_DONE;
      S_DONE:    if (bus.start) state_d = S_COLLECT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_COLLECT);
    bus.busy = (state_q == S_COLLECT);
    bus.done = (state_q == S_DONE);
  end

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    row_done_d = 1'b0;
    mem_d      = mem_q;
    // a beat offered while not ready is dropped and latched; start clears the old flag
    drop_err_d = (start_go ? 1'b0 : drop_err_q) | (bus.in_valid && !in_ready);
    if (start_go) begin
      row_d = '0;
      col_d = '0;
      mem_d = '0;
    end else if (accept) begin
      mem_d[row_q][col_q] = bus.in_data;
      if (last_col) begin
        col_d      = '0;
        row_d      = last_row ? '0 : row_q + 1'b1;
        row_done_d = 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    bus.read_data = '0;
    if (bus.read_row <= ROW_LAST && bus.read_col <= COL_LAST)
      bus.read_data = mem_q[bus.read_row][bus.read_col];
  end

  assign bus.in_ready = in_ready;
  assign bus.row_done = row_done_q;
  assign bus.fill_row = row_q;
  assign bus.fill_col = col_q;
  assign bus.drop_err = drop_err_q;
endmodule

// File: tb/tb_fm_wb_result_collector.sv
// Directed + randomized bench for fm_wb_result_collector against a flat-array beat-count model.
module tb_fm_wb_result_collector;
  localparam int NR = 6;
  localparam int NC = 3;
  localparam int NB = NR * NC;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  fm_wb_result_collector_if bus ();

  fm_wb_result_collector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: mode 0 idle / 1 collect / 2 done; k = accepted beats so far
  int          m_mode;
  int          m_k;
  logic        m_rd;
  logic        m_drop;
  logic [15:0] m_mem [NB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input int r, input int c);
    if (r < NR && c < NC) return m_mem[r * NC + c];
    return 16'h0;
  endfunction

  task automatic drive(input logic rst, input logic st, input logic v, input logic [15:0] d,
                       input int rr, input int rc);
    reset        = rst;
    bus.start    = st;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.read_row = 3'(rr);
    bus.read_col = 2'(rc);
  endtask

  task automatic check_model();
    @(negedge clk);
    chk("in_ready",  {31'd0, bus.in_ready}, {31'd0, m_mode == 1});
    chk("busy",      {31'd0, bus.busy},     {31'd0, m_mode == 1});
    chk("done",      {31'd0, bus.done},     {31'd0, m_mode == 2});
    chk("fill_row",  32'(bus.fill_row),     32'(m_k / NC));
    chk("fill_col",  32'(bus.fill_col),     32'(m_k % NC));
    chk("row_done",  {31'd0, bus.row_done}, {31'd0, m_rd});
    chk("drop_err",  {31'd0, bus.drop_err}, {31'd0, m_drop});
    chk("read_data", 32'(bus.read_data),    32'(m_read(int'(bus.read_row), int'(bus.read_col))));
  endtask

  task automatic tick();
    logic nrd;
    @(posedge clk);
    nrd = 1'b0;
    if (reset) begin
      m_mode = 0; m_k = 0; m_drop = 1'b0;
      foreach (m_mem[i]) m_mem[i] = 16'h0;
    end else if (bus.start && m_mode != 1) begin
      m_mode = 1; m_k = 0; m_drop = bus.in_valid;
      foreach (m_mem[i]) m_mem[i] = 16'h0;
    end else if (m_mode == 1) begin
      if (bus.in_valid) begin
        m_mem[m_k] = bus.in_data;
        if (m_k % NC == NC - 1) nrd = 1'b1;
        m_k++;
        if (m_k == NB) begin m_k = 0; m_mode = 2; end
      end
    end else if (bus.in_valid) begin
      m_drop = 1'b1;
    end
    m_rd = nrd;
    #1;
  endtask

  task automatic cyc(input logic rst, input logic st, input logic v, input logic [15:0] d,
                     input int rr, input int rc);
    drive(rst, st, v, d, rr, rc);
    check_model();
    tick();
  endtask

  // idle read cycle with a spec-fixed expected value on top of the model check
  task automatic rd_chk(input string tag, input int rr, input int rc, input logic [15:0] exp);
    drive(1'b0, 1'b0, 1'b0, 16'h0, rr, rc);
    check_model();
    chk(tag, 32'(bus.read_data), 32'(exp));
    tick();
  endtask

  task automatic fill(input int beats, input logic gaps);
    for (int i = 0; i < beats; i++) begin
      if (gaps) cyc(1'b0, 1'b0, 1'b0, 16'h5A5A, 0, 0);
      cyc(1'b0, 1'b0, 1'b1, 16'(i + 1), $urandom_range(7), $urandom_range(3));
    end
  endtask

  int rdone_cnt;

  initial begin
    n_chk = 0; n_fail = 0;
    m_mode = 0; m_k = 0; m_rd = 1'b0; m_drop = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 16'h0;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 0, 0);
    tick();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 0, 0);

    // 1: back-to-back fill with row_done counting
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 0, 0);
    rdone_cnt = 0;
    for (int i = 0; i < NB; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'(i + 1), 0, 0);
      if (bus.row_done) rdone_cnt++;
    end
    chk("t1_done", {31'd0, bus.done}, 32'd1);
    chk("t1_row_done_cnt", 32'(rdone_cnt), 32'd6);
    rd_chk("t1_r00", 0, 0, 16'd1);
    rd_chk("t1_r02", 0, 2, 16'd3);
    rd_chk("t1_r10", 1, 0, 16'd4);
    rd_chk("t1_r52", 5, 2, 16'd18);

    // 2: same fill with gaps
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 0, 0);
    fill(NB, 1'b1);
    chk("t2_done", {31'd0, bus.done}, 32'd1);
    chk("t2_drop", {31'd0, bus.drop_err}, 32'd0);
    rd_chk("t2_r31", 3, 1, 16'd11);

    // 3: beats while not ready
    cyc(1'b0, 1'b0, 1'b1, 16'hFFFF, 5, 2);
    chk("t3_drop_done", {31'd0, bus.drop_err}, 32'd1);
    rd_chk("t3_r52", 5, 2, 16'd18);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 16'h1234, 0, 0);
    chk("t3_drop_idle", {31'd0, bus.drop_err}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 0, 0);
    chk("t3_drop_clr", {31'd0, bus.drop_err}, 32'd0);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) rd_chk("t3_zero", r, c, 16'h0);

    // 4: start mid-fill is ignored
    fill(7, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 0, 0);
    chk("t4_row", 32'(bus.fill_row), 32'd2);
    chk("t4_col", 32'(bus.fill_col), 32'd1);
    for (int i = 7; i < NB; i++) cyc(1'b0, 1'b0, 1'b1, 16'(i + 1), 2, 0);
    chk("t4_done", {31'd0, bus.done}, 32'd1);
    rd_chk("t4_r20", 2, 0, 16'd7);

    // 5: reset mid-fill
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 0, 0);
    fill(10, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 0, 0);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_done", {31'd0, bus.done}, 32'd0);
    chk("t5_row", 32'(bus.fill_row), 32'd0);
    rd_chk("t5_r00", 0, 0, 16'h0);
    rd_chk("t5_r22", 2, 2, 16'h0);

    // 6: out-of-range reads and read-during-write
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 0, 0);
    fill(NB, 1'b0);
    rd_chk("t6_row6", 6, 0, 16'h0);
    rd_chk("t6_col3", 0, 3, 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 0, 0);
    fill(7, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'hBEEF, 2, 1);
    check_model();
    chk("t6_rdw_old", 32'(bus.read_data), 32'h0);
    tick();
    rd_chk("t6_rdw_new", 2, 1, 16'hBEEF);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(199) == 0), ($urandom_range(29) == 0), ($urandom_range(3) != 0),
          16'($urandom()), $urandom_range(7), $urandom_range(3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
